// File: rtl/render_pkg.sv
// Shared types and constants for the colour-detect overlay renderer.
package render_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_MASK = 2'd1,
      MODE_OVL  = 2'd2,
      MODE_ALL  = 2'd3
   } mode_e;

   localparam logic [23:0] DEF_MASK_COLOR  = 24'h00FF00;
   localparam logic [23:0] DEF_BOX_COLOR   = 24'hFFFF00;
   localparam logic [23:0] DEF_CROSS_COLOR = 24'hFF0000;
   localparam logic [23:0] DEF_LOST_COLOR  = 24'hFF00FF;

   function automatic int unsigned pix_w(input int unsigned dw);
      return 3 * dw;
   endfunction

endpackage

// File: rtl/render_track.sv
// Per-frame centre latching, lost-tracking detection and blink counter.
module render_track import render_pkg::*; #(
   parameter int HW          = 12,
   parameter int VW          = 11,
   parameter int BOX_HC      = 160,
   parameter int BOX_VC      = 120,
   parameter int LOST_FRAMES = 4,
   parameter int BLINK_BITS  = 5
) (
   input  logic          PClk,
   input  logic          Rst,
   input  logic [HW-1:0] VtcHCnt,
   input  logic [VW-1:0] VtcVCnt,
   input  logic [HW-1:0] center_h,
   input  logic [VW-1:0] center_v,
   input  logic          center_valid,
   output logic [HW-1:0] act_h,
   output logic [VW-1:0] act_v,
   output logic          lost,
   output logic          blink_msb
);

   localparam int MW = $clog2(LOST_FRAMES + 1);
   localparam logic [MW-1:0] MISS_MAX = MW'(LOST_FRAMES);

   logic                  fs;
   logic                  seen;
   logic [HW-1:0]         pend_h;
   logic [VW-1:0]         pend_v;
   logic [MW-1:0]         miss_cnt, miss_nxt;
   logic [BLINK_BITS-1:0] blink;

   assign fs = (VtcHCnt == '0) && (VtcVCnt == '0);

   always_comb begin
      // NOTE: default first so every path assigns miss_nxt and no latch is inferred.
      miss_nxt = miss_cnt;
      if (fs) begin
         if (seen || center_valid)
            miss_nxt = '0;
         else if (miss_cnt != MISS_MAX)
            miss_nxt = miss_cnt + 1'b1;
      end
   end

   // NOTE: non-blocking assignments keep all state updates concurrent at the edge.
   always_ff @(posedge PClk) begin
      if (Rst) begin
         seen     <= 1'b0;
         pend_h   <= HW'(BOX_HC);
         pend_v   <= VW'(BOX_VC);
         act_h    <= HW'(BOX_HC);
         act_v    <= VW'(BOX_VC);
         miss_cnt <= MISS_MAX;
         blink    <= '0;
         lost     <= 1'b1;
      end else begin
         miss_cnt <= miss_nxt;
         lost     <= (miss_nxt == MISS_MAX);
         if (center_valid) begin
            pend_h <= center_h;
            pend_v <= center_v;
         end
         if (fs) begin
            seen  <= 1'b0;
            blink <= blink + 1'b1;
            // A strobe on the frame-start cycle bypasses the pending register.
            if (center_valid) begin
               act_h <= center_h;
               act_v <= center_v;
            end else if (seen) begin
               act_h <= pend_h;
               act_v <= pend_v;
            end
         end else if (center_valid) begin
            seen <= 1'b1;
         end
      end
   end

   assign blink_msb = blink[BLINK_BITS-1];

endmodule

// File: rtl/render_overlay.sv
// Two-stage pixel pipeline merging mask tint, target box and tracking cross onto video.
module render_overlay import render_pkg::*; #(
   parameter int DW          = 8,
   parameter int HW          = 12,
   parameter int VW          = 11,
   parameter int BOX_HC      = 160,
   parameter int BOX_VC      = 120,
   parameter int BOX_HALF    = 16,
   parameter int CROSS_HALF  = 0,
   parameter int LOST_FRAMES = 4,
   parameter int BLINK_BITS  = 5,
   parameter logic [pix_w(DW)-1:0] MASK_COLOR  = DEF_MASK_COLOR,
   parameter logic [pix_w(DW)-1:0] BOX_COLOR   = DEF_BOX_COLOR,
   parameter logic [pix_w(DW)-1:0] CROSS_COLOR = DEF_CROSS_COLOR,
   parameter logic [pix_w(DW)-1:0] LOST_COLOR  = DEF_LOST_COLOR
) (
   input  logic                 PClk,
   input  logic                 Rst,
   input  logic [pix_w(DW)-1:0] RGB24,
   input  logic                 Binary_in,
   input  logic [HW-1:0]        VtcHCnt,
   input  logic [VW-1:0]        VtcVCnt,
   input  logic [HW-1:0]        center_h,
   input  logic [VW-1:0]        center_v,
   input  logic                 center_valid,
   input  logic [1:0]           mode,
   output logic [pix_w(DW)-1:0] RGB_render,
   output logic                 lost
);

   localparam int PW = pix_w(DW);
   localparam logic [HW-1:0] BOX_L  = HW'(BOX_HC - BOX_HALF);
   localparam logic [HW-1:0] BOX_R  = HW'(BOX_HC + BOX_HALF);
   localparam logic [VW-1:0] BOX_T  = VW'(BOX_VC - BOX_HALF);
   localparam logic [VW-1:0] BOX_B  = VW'(BOX_VC + BOX_HALF);
   localparam logic [HW-1:0] XH_LIM = HW'(CROSS_HALF);
   localparam logic [VW-1:0] XV_LIM = VW'(CROSS_HALF);

   logic [HW-1:0] act_h, dist_h;
   logic [VW-1:0] act_v, dist_v;
   logic          blink_msb;
   logic          box_hit, cross_on;

   render_track #(
      .HW(HW), .VW(VW), .BOX_HC(BOX_HC), .BOX_VC(BOX_VC),
      .LOST_FRAMES(LOST_FRAMES), .BLINK_BITS(BLINK_BITS)
   ) u_track (
      .PClk(PClk), .Rst(Rst), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
      .center_h(center_h), .center_v(center_v), .center_valid(center_valid),
      .act_h(act_h), .act_v(act_v), .lost(lost), .blink_msb(blink_msb)
   );

   // Distances are taken larger-minus-smaller so screen edges never wrap.
   assign dist_h = (VtcHCnt >= act_h) ? (VtcHCnt - act_h) : (act_h - VtcHCnt);
   assign dist_v = (VtcVCnt >= act_v) ? (VtcVCnt - act_v) : (act_v - VtcVCnt);

   assign box_hit = (((VtcHCnt == BOX_L) || (VtcHCnt == BOX_R)) &&
                     (VtcVCnt >= BOX_T) && (VtcVCnt <= BOX_B)) ||
                    (((VtcVCnt == BOX_T) || (VtcVCnt == BOX_B)) &&
                     (VtcHCnt >= BOX_L) && (VtcHCnt <= BOX_R));
   assign cross_on = ((dist_h <= XH_LIM) || (dist_v <= XV_LIM)) && (!lost || blink_msb);

   logic          box_q, cross_q, bin_q, lost_q;
   mode_e         mode_q;
   logic [PW-1:0] rgb_q, pix_mux;

   always_ff @(posedge PClk) begin
      if (Rst) begin
         box_q   <= 1'b0;
         cross_q <= 1'b0;
         bin_q   <= 1'b0;
         lost_q  <= 1'b0;
         mode_q  <= MODE_PASS;
         rgb_q   <= '0;
      end else begin
         box_q   <= box_hit;
         cross_q <= cross_on;
         bin_q   <= Binary_in;
         lost_q  <= lost;
         mode_q  <= mode_e'(mode);
         rgb_q   <= RGB24;
      end
   end

   always_comb begin
      pix_mux = rgb_q;
      if ((mode_q == MODE_OVL || mode_q == MODE_ALL) && box_q)
         pix_mux = BOX_COLOR;
      else if ((mode_q == MODE_OVL || mode_q == MODE_ALL) && cross_q)
         pix_mux = lost_q ? LOST_COLOR : CROSS_COLOR;
      else if ((mode_q == MODE_MASK || mode_q == MODE_ALL) && bin_q)
         pix_mux = MASK_COLOR;
   end

   always_ff @(posedge PClk) begin
      if (Rst) RGB_render <= '0;
      else     RGB_render <= pix_mux;
   end

endmodule

// File: tb/tb_render_overlay.sv
// Directed self-checking bench for render_overlay: vector table plus frame sequences.
module tb_render_overlay;

   logic        PClk = 1'b0;
   logic        Rst  = 1'b1;
   logic [23:0] RGB24 = '0;
   logic        Binary_in = 1'b0;
   logic [11:0] hcnt = 12'd1000;
   logic [10:0] vcnt = 11'd900;
   logic [11:0] center_h = '0;
   logic [10:0] center_v = '0;
   logic        center_valid = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] out1, out2;
   logic        lost1, lost2;

   int n_vec = 0;
   int n_err = 0;

   always #5 PClk = ~PClk;

   render_overlay dut (
      .PClk(PClk), .Rst(Rst), .RGB24(RGB24), .Binary_in(Binary_in),
      .VtcHCnt(hcnt), .VtcVCnt(vcnt), .center_h(center_h), .center_v(center_v),
      .center_valid(center_valid), .mode(mode), .RGB_render(out1), .lost(lost1)
   );

   render_overlay #(.CROSS_HALF(2)) dut2 (
      .PClk(PClk), .Rst(Rst), .RGB24(RGB24), .Binary_in(Binary_in),
      .VtcHCnt(hcnt), .VtcVCnt(vcnt), .center_h(center_h), .center_v(center_v),
      .center_valid(center_valid), .mode(mode), .RGB_render(out2), .lost(lost2)
   );

   typedef struct packed {
      logic [11:0] h;
      logic [10:0] v;
      logic [23:0] rgb;
      logic        bin;
      logic [1:0]  mode;
      logic [23:0] exp;
   } vec_t;

   vec_t        vecs[15];
   logic [23:0] hist[10];

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PClk);
      #1;
   endtask

   // Hold one pixel for two clocks so the output reflects it afterwards.
   task automatic pix(input logic [11:0] h, input logic [10:0] v, input logic [23:0] rgb,
                      input logic bin, input logic [1:0] m);
      hcnt = h; vcnt = v; RGB24 = rgb; Binary_in = bin; mode = m;
      tick();
      tick();
   endtask

   task automatic frame_start();
      hcnt = 12'd0; vcnt = 11'd0; center_valid = 1'b0;
      tick();
      hcnt = 12'd1000; vcnt = 11'd900;
   endtask

   task automatic strobe(input logic [11:0] h, input logic [10:0] v);
      hcnt = 12'd1000; vcnt = 11'd900;
      center_h = h; center_v = v; center_valid = 1'b1;
      tick();
      center_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{12'd144, 11'd120, 24'h123456, 1'b0, 2'd2, 24'hFFFF00};
      vecs[1]  = '{12'd145, 11'd103, 24'h234567, 1'b0, 2'd2, 24'h234567};
      vecs[2]  = '{12'd160, 11'd104, 24'h345678, 1'b0, 2'd2, 24'hFFFF00};
      vecs[3]  = '{12'd176, 11'd136, 24'h456789, 1'b0, 2'd2, 24'hFFFF00};
      vecs[4]  = '{12'd143, 11'd120, 24'h56789A, 1'b0, 2'd2, 24'h56789A};
      vecs[5]  = '{12'd160, 11'd103, 24'h6789AB, 1'b0, 2'd2, 24'h6789AB};
      vecs[6]  = '{12'd160, 11'd137, 24'h789ABC, 1'b0, 2'd2, 24'h789ABC};
      vecs[7]  = '{12'd160, 11'd120, 24'h89ABCD, 1'b0, 2'd2, 24'h89ABCD};
      vecs[8]  = '{12'd144, 11'd120, 24'h9ABCDE, 1'b1, 2'd3, 24'hFFFF00};
      vecs[9]  = '{12'd500, 11'd500, 24'hABCDEF, 1'b1, 2'd3, 24'h00FF00};
      vecs[10] = '{12'd144, 11'd120, 24'hBCDEF0, 1'b0, 2'd1, 24'hBCDEF0};
      vecs[11] = '{12'd144, 11'd120, 24'hCDEF01, 1'b1, 2'd1, 24'h00FF00};
      vecs[12] = '{12'd144, 11'd120, 24'hDEF012, 1'b1, 2'd0, 24'hDEF012};
      vecs[13] = '{12'd177, 11'd136, 24'hEF0123, 1'b0, 2'd2, 24'hEF0123};
      vecs[14] = '{12'd176, 11'd137, 24'hF01234, 1'b0, 2'd2, 24'hF01234};

      // Reset state
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_out%0d", i), out1, 24'h0);
         check($sformatf("rst_lost%0d", i), {23'd0, lost1}, 24'd1);
      end

      // Mode 0 ramp: bit-exact, two-cycle latency from the first pixel after release
      Rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         hist[i] = {8'(i * 17), 8'(255 - i), 8'(i * 5 + 3)};
         RGB24 = hist[i]; hcnt = 12'(300 + i); vcnt = 11'd300;
         mode = 2'd0; Binary_in = 1'(i % 2);
         tick();
         if (i >= 1) check($sformatf("ramp%0d", i - 1), out1, hist[i - 1]);
      end
      check("lost_after_rst", {23'd0, lost1}, 24'd1);

      // Static geometry/priority table (centre at default, lost, blink off)
      for (int i = 0; i < 15; i++) begin
         pix(vecs[i].h, vecs[i].v, vecs[i].rgb, vecs[i].bin, vecs[i].mode);
         check($sformatf("vec%0d", i), out1, vecs[i].exp);
      end

      // Centre latching happens only at frame start
      frame_start();                                  // fs1
      check("lost_fs1", {23'd0, lost1}, 24'd1);
      strobe(12'd100, 11'd80);
      pix(12'd100, 11'd300, 24'h0A0B0C, 1'b0, 2'd2);
      check("pre_latch", out1, 24'h0A0B0C);
      frame_start();                                  // fs2
      check("lost_fs2", {23'd0, lost1}, 24'd0);
      pix(12'd100, 11'd300, 24'h0A0B0C, 1'b0, 2'd2);
      check("cross_col100", out1, 24'hFF0000);
      pix(12'd300, 11'd80, 24'h0A0B0C, 1'b0, 2'd2);
      check("cross_row80", out1, 24'hFF0000);
      pix(12'd160, 11'd300, 24'h0A0B0C, 1'b0, 2'd2);
      check("old_default_off", out1, 24'h0A0B0C);
      strobe(12'd200, 11'd50);
      pix(12'd200, 11'd300, 24'h111111, 1'b0, 2'd2);
      check("midframe_new_off", out1, 24'h111111);
      pix(12'd100, 11'd300, 24'h111111, 1'b0, 2'd2);
      check("midframe_old_on", out1, 24'hFF0000);
      frame_start();                                  // fs3
      check("lost_fs3", {23'd0, lost1}, 24'd0);
      pix(12'd200, 11'd300, 24'h222222, 1'b0, 2'd2);
      check("new_col200", out1, 24'hFF0000);
      pix(12'd300, 11'd50, 24'h222222, 1'b0, 2'd2);
      check("new_row50", out1, 24'hFF0000);
      pix(12'd100, 11'd300, 24'h222222, 1'b0, 2'd2);
      check("old_col_gone", out1, 24'h222222);
      pix(12'd200, 11'd300, 24'h222222, 1'b1, 2'd3);
      check("cross_over_mask", out1, 24'hFF0000);
      pix(12'd200, 11'd300, 24'h222222, 1'b1, 2'd1);
      check("mask_only_mode1", out1, 24'h00FF00);

      // Per-pixel mode change, back to back
      hcnt = 12'd200; vcnt = 11'd300; RGB24 = 24'h333333; Binary_in = 1'b0; mode = 2'd2;
      tick();
      RGB24 = 24'h444444; mode = 2'd0;
      tick();
      check("mode_seq_ovl", out1, 24'hFF0000);
      tick();
      check("mode_seq_pass", out1, 24'h444444);

      // Loss of tracking and blinking
      frame_start();                                  // fs4
      frame_start();                                  // fs5
      frame_start();                                  // fs6
      check("lost_fs6", {23'd0, lost1}, 24'd0);
      frame_start();                                  // fs7, blink=7
      check("lost_fs7", {23'd0, lost1}, 24'd1);
      pix(12'd200, 11'd300, 24'h555555, 1'b0, 2'd2);
      check("lost_blink_off", out1, 24'h555555);
      for (int i = 0; i < 9; i++) frame_start();      // fs16, blink=16
      pix(12'd200, 11'd300, 24'h555555, 1'b0, 2'd2);
      check("lost_blink16_on", out1, 24'hFF00FF);
      for (int i = 0; i < 15; i++) frame_start();     // fs31, blink=31
      pix(12'd300, 11'd50, 24'h555555, 1'b0, 2'd2);
      check("lost_blink31_on", out1, 24'hFF00FF);
      frame_start();                                  // fs32, blink=0
      pix(12'd200, 11'd300, 24'h666666, 1'b0, 2'd2);
      check("lost_blink0_off", out1, 24'h666666);
      strobe(12'd220, 11'd60);
      check("lost_midframe", {23'd0, lost1}, 24'd1);
      frame_start();                                  // fs33
      check("lost_cleared", {23'd0, lost1}, 24'd0);
      pix(12'd220, 11'd300, 24'h777777, 1'b0, 2'd2);
      check("regained_cross", out1, 24'hFF0000);

      // Mid-frame reset
      hcnt = 12'd144; vcnt = 11'd120; RGB24 = 24'h888888; mode = 2'd2;
      tick();
      Rst = 1'b1;
      tick();
      check("midrst_out", out1, 24'h0);
      check("midrst_lost", {23'd0, lost1}, 24'd1);
      Rst = 1'b0;
      pix(12'd144, 11'd120, 24'h888888, 1'b0, 2'd2);
      check("post_rst_box", out1, 24'hFFFF00);
      pix(12'd220, 11'd300, 24'h999999, 1'b0, 2'd2);
      check("post_rst_cross_off", out1, 24'h999999);

      // Thick cross at the screen corner
      frame_start();
      strobe(12'd1, 11'd1);
      frame_start();
      check("thick_lost", {23'd0, lost2}, 24'd0);
      pix(12'd0, 11'd500, 24'hAAAAAA, 1'b0, 2'd2);
      check("thick_col0", out2, 24'hFF0000);
      check("thin_col0", out1, 24'hAAAAAA);
      pix(12'd1, 11'd500, 24'hAAAAAA, 1'b0, 2'd2);
      check("thin_col1", out1, 24'hFF0000);
      pix(12'd2, 11'd500, 24'hAAAAAA, 1'b0, 2'd2);
      check("thick_col2", out2, 24'hFF0000);
      check("thin_col2", out1, 24'hAAAAAA);
      pix(12'd3, 11'd500, 24'hAAAAAA, 1'b0, 2'd2);
      check("thick_col3", out2, 24'hFF0000);
      pix(12'd4, 11'd500, 24'hAAAAAA, 1'b0, 2'd2);
      check("thick_col4", out2, 24'hAAAAAA);
      pix(12'd500, 11'd0, 24'hBBBBBB, 1'b0, 2'd2);
      check("thick_row0", out2, 24'hFF0000);
      pix(12'd500, 11'd3, 24'hBBBBBB, 1'b0, 2'd2);
      check("thick_row3", out2, 24'hFF0000);
      pix(12'd500, 11'd4, 24'hBBBBBB, 1'b0, 2'd2);
      check("thick_row4", out2, 24'hBBBBBB);
      pix(12'd4095, 11'd500, 24'hCCCCCC, 1'b0, 2'd2);
      check("thick_col4095", out2, 24'hCCCCCC);
      check("thin_col4095", out1, 24'hCCCCCC);
      pix(12'd500, 11'd2047, 24'hCCCCCC, 1'b0, 2'd2);
      check("thick_row2047", out2, 24'hCCCCCC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
